// File: rtl/psum_drain_pkg.sv
// psum_drain shared types and helpers.
// Default geometry of the right-edge collector.
package psum_drain_pkg;

  localparam int ROWS_DEF   = 4;
  localparam int PSUM_W_DEF = 16;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic                               last;
    logic [ROWS_DEF*PSUM_W_DEF-1:0]     data;
  } psum_ent_t;

endpackage

// File: rtl/psum_deskew_line.sv
// Per-row valid+data delay line for the psum de-skew.
// DLY=0 degenerates to a wire from input to output.
module psum_deskew_line
  import psum_drain_pkg::*;
#(
  parameter int DLY = 0,
  parameter int W   = 16
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         CLR,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  localparam int NQ = (DLY > 0) ? DLY : 1;

  logic [W:0] q [NQ];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NQ; i++)
        q[i] <= '0;
    end else if (CLR) begin
      for (int i = 0; i < NQ; i++)
        q[i] <= '0;
    end else begin
      q[0] <= {in_vld, in_data};
      for (int i = 1; i < NQ; i++)
        q[i] <= q[i-1];
    end
  end

  assign {out_vld, out_data} =
    (DLY == 0) ? {in_vld, in_data} : q[NQ-1];

endmodule

// File: rtl/psum_drain.sv
// Right-edge psum collector: de-skew, FIFO, tile framing.
// Define PSUM_DRAIN_RELU_EN to clamp negative lanes at FIFO write.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int PSUM_W   = PSUM_W_DEF,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 4,
  parameter int LEN_W    = 8
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   CLR,
  input  logic [LEN_W-1:0]       CFG_LEN,
  input  logic [ROWS*PSUM_W-1:0] PSUM_IN,
  input  logic [ROWS-1:0]        PSUM_VLD,
  output logic [ROWS*PSUM_W-1:0] OUT_DATA,
  output logic                   OUT_VLD,
  input  logic                   OUT_RDY,
  output logic                   OUT_LAST,
  output logic                   STALL,
  output logic                   OVF,
  output logic                   SKEW_ERR
);

  localparam int PW = ptr_w(DEPTH);
  localparam int DW = ROWS * PSUM_W;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  logic [ROWS-1:0] a_vld;
  logic [DW-1:0]   a_data;
  logic [DW-1:0]   wr_data;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    psum_deskew_line #(
      .DLY (ROWS - 1 - r),
      .W   (PSUM_W)
    ) u_line (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .CLR      (CLR),
      .in_vld   (PSUM_VLD[r]),
      .in_data  (PSUM_IN[r*PSUM_W +: PSUM_W]),
      .out_vld  (a_vld[r]),
      .out_data (a_data[r*PSUM_W +: PSUM_W])
    );
  end

`ifdef PSUM_DRAIN_RELU_EN
  always_comb begin
    wr_data = a_data;
    for (int r = 0; r < ROWS; r++)
      if (a_data[r*PSUM_W + PSUM_W - 1])
        wr_data[r*PSUM_W +: PSUM_W] = '0;
  end
`else
  assign wr_data = a_data;
`endif

  ent_t             mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [LEN_W-1:0] tile_cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cur_len;
  logic             push;
  logic             pop;
  logic             accept;
  logic             full;
  logic             last_in;
  logic             skew;

  assign full    = (count == (PW+1)'(DEPTH));
  assign OUT_VLD = (count != '0);
  assign pop     = OUT_VLD & OUT_RDY;
  assign push    = a_vld[0];
  assign accept  = push & (~full | pop);
  assign skew    = (a_vld != {ROWS{a_vld[0]}});

  // The tile length is latched at the first vector of each tile.
  assign cur_len = (tile_cnt == '0) ? CFG_LEN : len_q;
  assign last_in = (tile_cnt == cur_len);

  always_ff @(posedge CLK) begin
    if (accept && !CLR)
      mem[wr_ptr] <= '{last: last_in, data: wr_data};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tile_cnt <= '0;
      len_q    <= '0;
      STALL    <= 1'b0;
      OVF      <= 1'b0;
      SKEW_ERR <= 1'b0;
    end else if (CLR) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tile_cnt <= '0;
      len_q    <= '0;
      STALL    <= 1'b0;
      OVF      <= 1'b0;
      SKEW_ERR <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr   <= wr_ptr + PW'(1);
        tile_cnt <= last_in ? '0 : tile_cnt + LEN_W'(1);
        if (tile_cnt == '0)
          len_q <= CFG_LEN;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        accept & ~pop: count <= count + (PW+1)'(1);
        pop & ~accept: count <= count - (PW+1)'(1);
        default: ;
      endcase
      if (push && !accept)
        OVF <= 1'b1;
      if (skew)
        SKEW_ERR <= 1'b1;
      STALL <= (count >= (PW+1)'(AFULL_TH));
    end
  end

  assign OUT_DATA = OUT_VLD ? mem[rd_ptr].data : '0;
  assign OUT_LAST = OUT_VLD ? mem[rd_ptr].last : 1'b0;

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: skewed stimulus against a queue model
// that aligns rows by arrival offset and tracks FIFO/tile state.
module tb_psum_drain;
  import psum_drain_pkg::*;

  localparam int ROWS  = ROWS_DEF;
  localparam int PW    = PSUM_W_DEF;
  localparam int DW    = ROWS * PW;
  localparam int CW    = DW + 1;
  localparam int DEPTH = 8;
  localparam int TH    = 4;
  localparam int LW    = 8;
  localparam int NC    = 1024;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          CLR;
  logic [LW-1:0] CFG_LEN;
  logic [DW-1:0] PSUM_IN;
  logic [ROWS-1:0] PSUM_VLD;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VLD;
  logic          OUT_RDY;
  logic          OUT_LAST;
  logic          STALL;
  logic          OVF;
  logic          SKEW_ERR;

  always #5 CLK = ~CLK;

  psum_drain #(
    .ROWS(ROWS), .PSUM_W(PW), .DEPTH(DEPTH),
    .AFULL_TH(TH), .LEN_W(LW)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .CFG_LEN(CFG_LEN),
    .PSUM_IN(PSUM_IN), .PSUM_VLD(PSUM_VLD),
    .OUT_DATA(OUT_DATA), .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY),
    .OUT_LAST(OUT_LAST), .STALL(STALL), .OVF(OVF),
    .SKEW_ERR(SKEW_ERR)
  );

  // drive schedule, indexed by cycle
  logic [ROWS-1:0] vs [NC];
  logic [PW-1:0]   ds [NC][ROWS];

  psum_ent_t q[$];
  int  tile_m, len_m;
  bit  ovf_m, skew_m, stall_m;
  int  cyc, n_chk, n_pass;
  bit  rdy, clr;

  task automatic chk(input string tag, input logic [CW-1:0] obs,
                     input logic [CW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h",
                tag, cyc, obs, exp);
  endtask

  function automatic logic [PW-1:0] relu(input logic [PW-1:0] x);
`ifdef PSUM_DRAIN_RELU_EN
    return x[PW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  task automatic zap(input int upto);
    for (int i = 0; i <= upto && i < NC; i++) begin
      vs[i] = '0;
      for (int r = 0; r < ROWS; r++) ds[i][r] = '0;
    end
  endtask

  // row r of a vector enters r cycles after row 0 (late row: +1)
  task automatic put_vec(input int c0, input logic [DW-1:0] v,
                         input int late);
    for (int r = 0; r < ROWS; r++) begin
      int c;
      c = c0 + r + ((r == late) ? 1 : 0);
      if (c < NC) begin
        vs[c][r] = 1'b1;
        ds[c][r] = v[r*PW +: PW];
      end
    end
  endtask

  function automatic logic [DW-1:0] lanes(input int k);
    logic [DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*PW +: PW] = PW'(10*r + k);
    return v;
  endfunction

  // effect of the clock edge at the end of cycle cyc
  task automatic model_edge();
    logic [ROWS-1:0] av;
    logic [DW-1:0]   ad;
    psum_ent_t       e;
    int sz, idx;
    bit pop;
    sz  = q.size();
    pop = (sz > 0) && rdy;
    if (clr) begin
      q.delete();
      tile_m = 0; ovf_m = 0; skew_m = 0; stall_m = 0;
      zap(cyc);
      return;
    end
    stall_m = (sz >= TH);
    for (int r = 0; r < ROWS; r++) begin
      idx = cyc - (ROWS - 1) + r;
      av[r] = (idx >= 0) ? vs[idx][r] : 1'b0;
      ad[r*PW +: PW] = (idx >= 0) ? relu(ds[idx][r]) : '0;
    end
    if (pop) void'(q.pop_front());
    if (av[0]) begin
      if (sz < DEPTH || pop) begin
        if (tile_m == 0) len_m = int'(CFG_LEN);
        e.last = (tile_m == len_m);
        e.data = ad;
        q.push_back(e);
        tile_m = e.last ? 0 : tile_m + 1;
      end else begin
        ovf_m = 1;
      end
    end
    if (av != {ROWS{av[0]}}) skew_m = 1;
  endtask

  task automatic compare();
    psum_ent_t h;
    bit v;
    h = '0;
    v = (q.size() > 0);
    if (v) h = q[0];
    chk("out_vld",  CW'(OUT_VLD),  CW'(v));
    chk("out_data", CW'(OUT_DATA), CW'(h.data));
    chk("out_last", CW'(OUT_LAST), CW'(h.last));
    chk("stall",    CW'(STALL),    CW'(stall_m));
    chk("ovf",      CW'(OVF),      CW'(ovf_m));
    chk("skew_err", CW'(SKEW_ERR), CW'(skew_m));
  endtask

  task automatic step();
    PSUM_VLD = vs[cyc];
    for (int r = 0; r < ROWS; r++) PSUM_IN[r*PW +: PW] = ds[cyc][r];
    OUT_RDY = rdy;
    CLR     = clr;
    model_edge();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    compare();
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_vld"},  CW'(OUT_VLD),  '0);
    chk({tag, "_data"}, CW'(OUT_DATA), '0);
    chk({tag, "_last"}, CW'(OUT_LAST), '0);
    chk({tag, "_stall"}, CW'(STALL),   '0);
    chk({tag, "_ovf"},  CW'(OVF),      '0);
    chk({tag, "_skew"}, CW'(SKEW_ERR), '0);
  endtask

  initial begin
    int c0;
    n_chk = 0; n_pass = 0; cyc = 0;
    tile_m = 0; len_m = 0; ovf_m = 0; skew_m = 0; stall_m = 0;
    rdy = 1'b0; clr = 1'b0;
    zap(NC - 1);
    RSTN = 1'b0; CLR = 1'b0; CFG_LEN = 8'd3;
    PSUM_IN = '0; PSUM_VLD = '0; OUT_RDY = 1'b0;
    #1 chk_zero_outs("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;

    // skewed burst, consumer always ready
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) put_vec(cyc + 1 + k, lanes(k), -1);
    repeat (12) step();

    // back-pressure until full
    rdy = 1'b0;
    for (int k = 0; k < 8; k++)
      put_vec(cyc + 1 + k, {$urandom, $urandom}, -1);
    repeat (12) step();

    // full FIFO with a pop in the push cycle
    c0 = cyc + 1;
    put_vec(c0, {$urandom, $urandom}, -1);
    while (cyc < c0 + 3) step();
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    step();
    chk("ovf_full_pop", CW'(OVF), '0);

    // push into a full FIFO with no pop is dropped
    put_vec(cyc + 1, {$urandom, $urandom}, -1);
    repeat (5) step();
    chk("ovf_drop", CW'(OVF), CW'(1'b1));
    rdy = 1'b1;
    repeat (12) step();

    // tile framing with length 3
    CFG_LEN = 8'd2;
    clr = 1'b1; step(); clr = 1'b0;
    for (int k = 0; k < 7; k++)
      put_vec(cyc + 1 + k, {$urandom, $urandom}, -1);
    repeat (20) begin
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    rdy = 1'b1;
    repeat (8) step();

    // skew fault on row 2
    CFG_LEN = 8'd1;
    put_vec(cyc + 1, lanes(1), -1);
    put_vec(cyc + 6, lanes(2), 2);
    put_vec(cyc + 11, lanes(3), -1);
    repeat (18) step();
    chk("skew_set", CW'(SKEW_ERR), CW'(1'b1));
    clr = 1'b1; step(); clr = 1'b0;
    chk("skew_clr", CW'(SKEW_ERR), '0);
    for (int k = 0; k < 3; k++)
      put_vec(cyc + 1 + k, lanes(k + 5), -1);
    repeat (10) step();

    // random traffic, starting with a +/-5 lane vector
    CFG_LEN = LW'($urandom_range(0, 4));
    clr = 1'b1; step(); clr = 1'b0;
    put_vec(cyc + 1, {16'd5, 16'hFFFB, 16'd5, 16'hFFFB}, -1);
    for (int i = 0; i < 150; i++) begin
      if (i > 0 && $urandom_range(0, 1) == 1)
        put_vec(cyc + 1, {$urandom, $urandom}, -1);
      rdy = ($urandom_range(0, 9) < 7);
      step();
    end
    rdy = 1'b1;
    repeat (15) step();

    // asynchronous reset mid-burst
    for (int k = 0; k < 4; k++) put_vec(cyc + 1 + k, lanes(k + 40), -1);
    repeat (5) step();
    #2 RSTN = 1'b0;
    #1 chk_zero_outs("rst_mid");
    q.delete();
    tile_m = 0; ovf_m = 0; skew_m = 0; stall_m = 0;
    zap(NC - 1);
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    RSTN = 1'b1;
    compare();
    CFG_LEN = 8'd3;
    for (int k = 0; k < 4; k++) put_vec(cyc + 1 + k, lanes(k + 60), -1);
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
